// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the SPI master.
package spi_pkg;

    localparam int SPI_WORD_W = 32;
    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } spi_state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timebase: one-cycle tick every CLK_DIV enabled cycles.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    logic [7:0] count;

    assign tick = enable && (count == 8'(CLK_DIV - 1));

    // Count enabled cycles; restart on every tick and whenever disabled.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (rst || !enable || tick) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode 0 master: one WORD_W-bit full-duplex word per chip-select frame, MSB first.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int WORD_W  = SPI_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_ss,
    input  logic              i_miso,
    output logic [WORD_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_busy
);

    localparam int BIT_CNT_W = $clog2(WORD_W + 1);

    spi_state_t           state, state_next;
    logic [WORD_W-1:0]    tx_shift, tx_next;
    logic [WORD_W-1:0]    rx_shift, rx_next;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic                 sclk_next, mosi_next, ss_next;
    logic                 ready_next, busy_next, rx_valid_next;
    logic [WORD_W-1:0]    rx_data_next;
    logic                 tick;
    logic                 clk_en;

    // The timebase idles in IDLE, so it restarts from zero on every frame.
    assign clk_en = (state != IDLE);

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk   (clk),
        .rst   (rst),
        .enable(clk_en),
        .tick  (tick)
    );

    // State and all registered outputs; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            o_sclk     <= 1'b0;
            o_mosi     <= 1'b0;
            o_ss       <= 1'b1;
            o_ready    <= 1'b1;
            o_busy     <= 1'b0;
            o_rx_valid <= 1'b0;
            o_rx_data  <= '0;
        end else begin
            state      <= state_next;
            tx_shift   <= tx_next;
            rx_shift   <= rx_next;
            bit_cnt    <= bit_cnt_next;
            o_sclk     <= sclk_next;
            o_mosi     <= mosi_next;
            o_ss       <= ss_next;
            o_ready    <= ready_next;
            o_busy     <= busy_next;
            o_rx_valid <= rx_valid_next;
            o_rx_data  <= rx_data_next;
        end
    end

    // Next-state and next-output logic, advanced by the half-period tick.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_next    = state;
        tx_next       = tx_shift;
        rx_next       = rx_shift;
        bit_cnt_next  = bit_cnt;
        sclk_next     = o_sclk;
        mosi_next     = o_mosi;
        ss_next       = o_ss;
        ready_next    = o_ready;
        busy_next     = o_busy;
        rx_valid_next = 1'b0;
        rx_data_next  = o_rx_data;

        case (state)
            IDLE: begin
                if (i_valid && o_ready) begin
                    tx_next      = i_data;
                    rx_next      = '0;
                    bit_cnt_next = '0;
                    mosi_next    = i_data[WORD_W-1];
                    ss_next      = 1'b0;
                    ready_next   = 1'b0;
                    busy_next    = 1'b1;
                    state_next   = SETUP;
                end
            end

            SETUP: begin
                // Leaving SETUP is rising edge 0, so MISO is sampled here too.
                if (tick) begin
                    sclk_next    = 1'b1;
                    rx_next      = {rx_shift[WORD_W-2:0], i_miso};
                    bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                    state_next   = XFER;
                end
            end

            XFER: begin
                if (tick) begin
                    if (!o_sclk) begin
                        sclk_next    = 1'b1;
                        rx_next      = {rx_shift[WORD_W-2:0], i_miso};
                        bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_cnt == BIT_CNT_W'(WORD_W)) begin
                            mosi_next  = 1'b0;
                            state_next = HOLD;
                        end else begin
                            tx_next   = tx_shift << 1;
                            mosi_next = tx_next[WORD_W-1];
                        end
                    end
                end
            end

            HOLD: begin
                if (tick) begin
                    ss_next       = 1'b1;
                    rx_data_next  = rx_shift;
                    rx_valid_next = 1'b1;
                    state_next    = GAP;
                end
            end

            GAP: begin
                if (tick) begin
                    ready_next = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode 0 master (CPOL=0, CPHA=0) that drives one 32-bit word per chip-select frame to the FPGA-side SPI slave.
- Sends the word MSB first, as 4 bytes back to back, with no gap between bytes.
- Samples MISO at the same time, so it receives a 32-bit word in full duplex.
- Used as the on-chip SPI initiator for loopback and bring-up of the face-recognition data link. It is fed by a valid/ready word interface.

Parameters:
- CLK_DIV, 4, system clk cycles per SCLK half-period (legal range 1 to 255).
- WORD_W, 32, bits per frame (must be a multiple of 8).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- i_valid  input  1  transmit word available
- i_data  input  WORD_W  word to transmit
- o_ready  output  1  master idle and able to accept a word
- o_sclk  output  1  SPI clock, idles low
- o_mosi  output  1  master out, slave in
- o_ss  output  1  chip select, active low, idles high
- i_miso  input  1  master in, slave out (assumed synchronous to clk by board timing)
- o_rx_data  output  WORD_W  word captured from MISO
- o_rx_valid  output  1  one-cycle strobe, o_rx_data is valid
- o_busy  output  1  frame in progress (the inverse of o_ready)

Behaviour:
- All outputs are registered. Reset values: o_ss=1, o_sclk=0, o_mosi=0, o_ready=1, o_busy=0, o_rx_valid=0, o_rx_data=0.
- States:
  - IDLE: waiting for a word.
  - SETUP: o_ss low, first bit on MOSI.
  - XFER: SCLK toggling.
  - HOLD: SCLK low, o_ss still low.
  - GAP: o_ss high, minimum deselect time.
- IDLE: a word is accepted on the cycle where i_valid and o_ready are both 1 (call this cycle T).
  - i_data is latched into the TX shift register.
  - On the next cycle: o_ss=0, o_mosi=i_data[WORD_W-1], o_ready=0, and the state moves to SETUP.
- A half-period counter restarts at every state entry and at every SCLK toggle.
- SETUP: lasts CLK_DIV cycles, then o_sclk goes 1 and the state moves to XFER.
- XFER, rising edge of SCLK: i_miso is shifted into the RX shift register LSB first in arrival order, so the first bit received ends up as the MSB.
- XFER, falling edge of SCLK: the TX register shifts left with 0 fill, and o_mosi takes the new MSB.
- XFER ends after WORD_W rising edges and WORD_W falling edges. At the final falling edge o_mosi=0 and the state moves to HOLD.
- HOLD: lasts CLK_DIV cycles.
  - At its end: o_ss=1, o_rx_data is loaded from the RX register, and o_rx_valid pulses for exactly 1 cycle.
  - The state then moves to GAP.
- GAP: lasts CLK_DIV cycles, then the state moves to IDLE with o_ready=1.
- Timing relative to T:
  - o_ss falls at T+1.
  - Rising edge k (k=0..WORD_W-1) at T+1+CLK_DIV*(2k+1).
  - Falling edge k at T+1+CLK_DIV*(2k+2).
  - o_ss rises and o_rx_valid pulses at T+1+CLK_DIV*(2*WORD_W+1).
  - o_ready returns at T+1+CLK_DIV*(2*WORD_W+2).
- Bit counter: ceil(log2(WORD_W+1)) bits wide. It counts rising edges and is compared for equality only.
- Back-to-back words: i_valid held high is accepted on the first cycle o_ready=1. Every frame is separated by at least CLK_DIV cycles with o_ss high, which resets the slave's byte and bit counters.
- i_valid while o_ready=0: ignored. i_data after acceptance: don't-care.
- rst in any state: the next cycle shows the reset values above.
  - The frame is abandoned and o_ss rises immediately.
  - No o_rx_valid is produced, and o_rx_data keeps its reset value of 0.
- CLK_DIV=1: SCLK runs at clk/2 and every state lasts 1 cycle. No special-casing.

Decomposition:
- Package spi_pkg holds:
  - constants SPI_WORD_W=32 and SPI_BYTE_W=8;
  - the state enum (IDLE, SETUP, XFER, HOLD, GAP).
- One sub-module, spi_clk_gen:
  - inputs: clk, rst, enable;
  - produces a half-period tick strobe every CLK_DIV cycles while enabled;
  - clears its count when enable is low.
- The main FSM uses the tick to toggle o_sclk and to advance the SETUP, HOLD and GAP timers.

Test Plan:
- Basic transmit, CLK_DIV=4: send i_data=0xA5C3_0F81 with i_miso=0.
  - o_ss falls at T+1 and the first SCLK rise is at T+5.
  - MOSI sampled at the 32 rising edges reads 0xA5C30F81.
  - o_ss rises at T+261 and o_ready returns at T+265.
- Loopback: tie i_miso to o_mosi and send 0xDEAD_BEEF.
  - o_rx_valid pulses once with o_rx_data=0xDEADBEEF.
  - A behavioural mode-0 slave model assembles 4 bytes DE, AD, BE, EF.
- Back-to-back: hold i_valid=1 and send 0x00000001 then 0xFFFFFFFF.
  - Both words are accepted, giving two o_ss low frames.
  - o_ss is high for at least 4 cycles between them.
  - Exactly two o_rx_valid pulses occur.
- Busy rejection: pulse i_valid with 0x12345678 during XFER of 0x11111111.
  - Only 0x11111111 appears on MOSI.
  - No second frame starts.
- Reset mid-frame: assert rst after the 10th rising edge.
  - The next cycle shows o_ss=1, o_sclk=0, o_mosi=0, o_ready=1.
  - No o_rx_valid occurs.
  - A new word then transfers correctly.
- CLK_DIV=1: send 0x80000001.
  - SCLK toggles every cycle.
  - The MSB and LSB are observed at rising edges 0 and 31.
  - o_ready returns at T+67.
